mem_bus_responder: RTL

- Bounded-latency memory slave model that sits directly downstream of the core's imem or dmem port in the formal and simulation environments. One instance per port.
- Consumes the core's request bus and produces the gnt/err/rdata response.
- Backing store is a small word array. An error region is programmable.
- Stalls are driven by a free input, but their length is bounded so the core always makes progress.
- A sticky protocol-violation flag catches requests that change or drop while stalled.

---
 rtl/mem_bus_pkg.sv | 15 +
 rtl/mem_bus_responder_if.sv | 17 +
 rtl/mem_bus_store.sv | 25 ++
 rtl/mem_bus_responder.sv | 66 ++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and default constants for the memory bus responder.
package mem_bus_pkg;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;
    localparam logic [ADDR_W-1:0] ERR_BASE_DEF = 64'h0000_0000_0000_F000;
    localparam logic [ADDR_W-1:0] ERR_MASK_DEF = 64'h0000_0000_0000_F000;
    typedef enum logic {IDLE, STALL} state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] wdata;
    } req_t;
endpackage

// File: rtl/mem_bus_responder_if.sv
// mem_bus_responder_if: core request bus and its zero-latency response.
interface mem_bus_responder_if #(
    parameter int MEM_ADDR_W = 64,
    parameter int MEM_DATA_W = 64,
    parameter int MEM_STRB_W = 8
);
    logic                  req;
    logic [MEM_ADDR_W-1:0] addr;
    logic                  wen;
    logic [MEM_STRB_W-1:0] strb;
    logic [MEM_DATA_W-1:0] wdata;
    logic                  gnt;
    logic                  err;
    logic [MEM_DATA_W-1:0] rdata;
    modport master (output req, addr, wen, strb, wdata, input gnt, err, rdata);
    modport slave  (input req, addr, wen, strb, wdata, output gnt, err, rdata);
endinterface

// File: rtl/mem_bus_store.sv
// mem_bus_store: byte-strobed word array with synchronous clear, async read, strobed write.
module mem_bus_store #(
    parameter int DATA_W  = 64,
    parameter int STRB_W  = 8,
    parameter int DEPTH_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [DEPTH_W-1:0] widx,
    input  logic [STRB_W-1:0]  strb,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [DEPTH_W-1:0] ridx,
    output logic [DATA_W-1:0]  rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_W];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**DEPTH_W; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) if (strb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
    assign rdata = mem[ridx];
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: bounded-stall memory slave with error region and sticky protocol checker.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int MEM_ADDR_W = 64,
    parameter int MEM_DATA_W = 64,
    parameter int MEM_STRB_W = 8,
    parameter int DEPTH_W    = 4,
    parameter int MAX_STALL  = 3,
    parameter logic [MEM_ADDR_W-1:0] ERR_BASE = ERR_BASE_DEF,
    parameter logic [MEM_ADDR_W-1:0] ERR_MASK = ERR_MASK_DEF
) (
    input  logic                g_clk,
    input  logic                g_reset,
    mem_bus_responder_if.slave  bus,
    input  logic                stall_req,
    output logic                proto_err,
    output logic [15:0]         n_txn
);
    localparam int OFF_W = $clog2(MEM_STRB_W);
    localparam int CNT_W = $clog2(MAX_STALL + 2);
    state_t             state;
    logic [CNT_W-1:0]   stall_cnt;
    req_t               cur, lat;
    logic [DEPTH_W-1:0] idx;
    logic               hit, wr;
    logic [MEM_DATA_W-1:0] mem_rdata;
    assign cur = '{addr: bus.addr, wen: bus.wen, strb: bus.strb, wdata: bus.wdata};
    assign idx = bus.addr[DEPTH_W+OFF_W-1:OFF_W];
    assign hit = (bus.addr & ERR_MASK) == ERR_BASE;
    // A saturated stall counter overrides the stall wish, bounding latency.
    assign bus.gnt   = bus.req && !g_reset && (!stall_req || stall_cnt == CNT_W'(MAX_STALL));
    assign bus.err   = bus.gnt && hit;
    assign bus.rdata = (bus.gnt && !bus.wen && !hit) ? mem_rdata : '0;
    assign wr        = bus.gnt && bus.wen && !hit;
    mem_bus_store #(.DATA_W(MEM_DATA_W), .STRB_W(MEM_STRB_W), .DEPTH_W(DEPTH_W)) u_store (
        .clk(g_clk), .rst(g_reset), .we(wr), .widx(idx), .strb(bus.strb),
        .wdata(bus.wdata), .ridx(idx), .rdata(mem_rdata)
    );
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state     <= IDLE;
            stall_cnt <= '0;
            n_txn     <= '0;
            proto_err <= 1'b0;
            lat       <= '0;
        end else begin
            if (state == IDLE) begin
                if (bus.req && !bus.gnt) begin
                    state     <= STALL;
                    lat       <= cur;
                    stall_cnt <= CNT_W'(1);
                end
            end else begin
                if (!bus.req || cur != lat) proto_err <= 1'b1;
                if (!bus.req || bus.gnt) begin
                    state     <= IDLE;
                    stall_cnt <= '0;
                end else if (stall_cnt != CNT_W'(MAX_STALL)) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
            n_txn <= n_txn + 16'(bus.gnt);
        end
    end
endmodule
